// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-2 Booth multiplier with valid/ready handshakes.
// Operands are extended to WIDTH+1 bits so a single datapath serves signed and
// unsigned products; WIDTH+1 Booth steps run, then the result waits in DONE.
module booth_seq_mult #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_inputA,
    input  logic [WIDTH-1:0]     i_inputB,
    input  logic                 i_signed,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_busy
);

    localparam int unsigned CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH:0]      acc_a;
    logic [WIDTH:0]      reg_q;
    logic [WIDTH:0]      reg_m;
    logic                q_m1;
    logic [CW-1:0]       count;
    logic                accept;
    logic                last_step;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      a_next;
    logic [WIDTH:0]      q_next;
    logic [2*WIDTH+1:0]  prod_next;

    assign accept    = i_valid && o_ready;
    assign last_step = (count == CW'(1));

    // State register; reset wins over any handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready) begin
                    state_next = i_valid ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One Booth step: add/subtract M per {Q[0],Q-1}, then arithmetic shift right.
    always_comb begin
        sum = acc_a;
        case ({reg_q[0], q_m1})
            2'b01:   sum = acc_a + reg_m;
            2'b10:   sum = acc_a - reg_m;
            default: sum = acc_a;
        endcase
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], reg_q[WIDTH:1]};
        prod_next = {a_next, q_next};
    end

    // Datapath: operand capture on acceptance, iteration in RUN, result latch on last step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_a    <= '0;
            reg_q    <= '0;
            reg_m    <= '0;
            q_m1     <= 1'b0;
            count    <= '0;
            o_result <= '0;
        end else if (accept) begin
            reg_m <= {i_signed & i_inputA[WIDTH-1], i_inputA};
            reg_q <= {i_signed & i_inputB[WIDTH-1], i_inputB};
            acc_a <= '0;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH + 1);
        end else if (state == RUN) begin
            acc_a <= a_next;
            reg_q <= q_next;
            q_m1  <= reg_q[0];
            count <= count - CW'(1);
            if (last_step) begin
                o_result <= prod_next[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and randomised checks of booth_seq_mult (WIDTH=32)
// against a scoreboard of products computed with native multiplication.
module tb_booth_seq_mult;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready = 1'b0;
    logic             sgn = 1'b0;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             out_ready;
    logic             out_valid;
    logic             busy;
    logic [2*W-1:0]   result;

    int unsigned      n_checks = 0;
    int unsigned      n_pass = 0;
    int unsigned      cyc = 0;
    logic [2*W-1:0]   exp_q[$];

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_inputA (in_a),
        .i_inputB (in_b),
        .i_signed (sgn),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_result (result),
        .o_busy   (busy)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        if (s) begin
            return 64'(longint'($signed(a)) * longint'($signed(b)));
        end
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        return ua * ub;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: drive at negedge, resolve handshakes, advance past the rising edge.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic r, input logic x, output logic acc);
        logic cons;
        @(negedge clk);
        rst = x; in_valid = v; in_a = a; in_b = b; sgn = s; in_ready = r;
        #1;
        acc  = v && out_ready && !x;
        cons = out_valid && r && !x;
        if (x) begin
            exp_q.delete();
        end else begin
            if (cons) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
                else chk("result", result, exp_q.pop_front());
            end
            if (acc) exp_q.push_back(model(a, b, s));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(output int unsigned n);
        logic acc;
        n = 0;
        while (!out_valid && n < 100) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic acc;
        int unsigned n;
        step(1'b1, a, b, s, 1'b0, 1'b0, acc);
        chk("op_accept", 64'(acc), 64'd1);
        wait_valid(n);
        chk("op_latency", 64'(n), 64'd33);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic           acc;
        int unsigned    n;
        int unsigned    last;
        int unsigned    idx;
        int unsigned    guard;
        int unsigned    seen;
        int unsigned    issued;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [W-1:0]   corners[5];
        logic [W-1:0]   b2b_a[5];
        logic [W-1:0]   b2b_b[5];
        logic           b2b_s[5];

        // Reset state.
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        chk("rst_ready", 64'(out_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);

        // Signed -1 * -1 with latency and RUN-state outputs.
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, acc);
        chk("m1_accept", 64'(acc), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_ready", 64'(out_ready), 64'd0);
        step(1'b1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, acc);
        chk("run_ignores_valid", 64'(acc), 64'd0);
        wait_valid(n);
        chk("m1_latency", 64'(n + 1), 64'd33);
        chk("m1_value", result, 64'h0000_0000_0000_0001);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        chk("m1_idle_ready", 64'(out_ready), 64'd1);

        // Unsigned max*max, then backpressure for 10 cycles.
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, acc);
        wait_valid(n);
        chk("umax_latency", 64'(n), 64'd33);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, acc);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(out_ready), 64'd0);
            chk("bp_noaccept", 64'(acc), 64'd0);
            chk("bp_stable", result, 64'hFFFF_FFFE_0000_0001);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        chk("bp_idle_ready", 64'(out_ready), 64'd1);
        chk("bp_idle_valid", 64'(out_valid), 64'd0);

        // Signed most-negative squared.
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);

        // Back-to-back with continuous valid/ready.
        b2b_a = '{32'd7, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        b2b_b = '{32'hFFFF_FFFD, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0};
        b2b_s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        idx = 0; last = 0; guard = 0;
        while ((idx < 4 || exp_q.size() > 0) && guard < 400) begin
            step(idx < 4, b2b_a[idx], b2b_b[idx], b2b_s[idx], 1'b1, 1'b0, acc);
            if (acc) begin
                if (idx > 0) chk("b2b_spacing", 64'(cyc - last), 64'd34);
                last = cyc;
                idx++;
            end
            guard++;
        end
        chk("b2b_done", 64'(idx), 64'd4);
        chk("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of RUN discards the operation.
        step(1'b1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < 14; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(out_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        run_op(32'd12, 32'd12, 1'b0);

        // Randomised operands, signedness and handshake stalls.
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        issued = 0; guard = 0;
        while ((issued < 300 || exp_q.size() > 0) && guard < 20000) begin
            ra = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            step((issued < 300) && ($urandom_range(0, 9) < 7), ra, rb, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 7), 1'b0, acc);
            if (acc) issued++;
            guard++;
        end
        chk("rand_issued", 64'(issued), 64'd300);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
